// File: rtl/nibble_serial_subtractor_16bit.sv
// Multi-cycle subtractor: A - B - Bin computed one SLICE-bit chunk per cycle
// through a carry-lookahead slice on A + ~B + ~Bin, behind a start/done handshake.
module nibble_serial_subtractor_16bit #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, ovf_q, done_q;

    logic             load, step, finish;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [SLICE-1:0] a_sl, b_sl, g, p, s;
    logic [SLICE:0]   c;
    logic             cc, pp;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (idx_q == IW'(N - 1)) state_d = S_DONE;
            S_DONE: state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control decode from the current state
    always_comb begin
        load   = start && (state_q == S_IDLE || state_q == S_DONE);
        step   = (state_q == S_RUN);
        finish = (state_q == S_DONE);
    end

    // Carry-lookahead slice: each carry is a flat OR of generate terms
    // gated by the propagate products above them, plus the incoming carry.
    always_comb begin
        a_sh = a_q >> (int'(idx_q) * SLICE);
        b_sh = b_q >> (int'(idx_q) * SLICE);
        a_sl = a_sh[SLICE-1:0];
        b_sl = ~b_sh[SLICE-1:0];
        g    = a_sl & b_sl;
        p    = a_sl ^ b_sl;
        c    = '0;
        cc   = 1'b0;
        pp   = 1'b1;
        c[0] = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            cc = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & carry_q);
        end
        s = p ^ c[SLICE-1:0];
        acc_d = acc_q;
        acc_d[int'(idx_q)*SLICE +: SLICE] = s;
    end

    // Operand capture, slice accumulation and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                diff_q   <= acc_q;
                borrow_q <= ~carry_q;
                ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (acc_q[WIDTH-1] != a_q[WIDTH-1]);
            end
            if (step) begin
                acc_q   <= acc_d;
                carry_q <= c[SLICE];
                idx_q   <= idx_q + 1'b1;
            end
            if (load) begin
                a_q     <= A;
                b_q     <= B;
                carry_q <= ~Bin;
                idx_q   <= '0;
                acc_q   <= '0;
            end
        end
    end

    // Outputs
    always_comb begin
        diff     = diff_q;
        borrow   = borrow_q;
        overflow = ovf_q;
        busy     = (state_q == S_RUN);
        done     = done_q;
    end

endmodule

// File: tb/tb_nibble_serial_subtractor_16bit.sv
// Scoreboard bench for nibble_serial_subtractor_16bit.
// Expected results are queued at issue and popped when done pulses.
module tb_nibble_serial_subtractor_16bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Bin = 1'b0;
    logic [15:0] diff;
    logic        borrow, overflow, busy, done;

    typedef struct packed {
        logic [15:0] d;
        logic        b;
        logic        o;
    } res_t;

    res_t sbq[$];
    res_t exp_r;
    int   n_checks = 0;
    int   n_fail = 0;

    nibble_serial_subtractor_16bit dut (
        .clk(clk), .rst(rst), .start(start),
        .A(A), .B(B), .Bin(Bin),
        .diff(diff), .borrow(borrow), .overflow(overflow),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic bi);
        logic [16:0] w;
        res_t r;
        w   = {1'b0, a} - {1'b0, b} - {16'd0, bi};
        r.d = w[15:0];
        r.b = w[16];
        r.o = (a[15] != b[15]) && (w[15] != a[15]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bi);
        A = a; B = b; Bin = bi; start = 1'b1;
        sbq.push_back(model(a, b, bi));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int nbusy);
        cyc = 0;
        nbusy = busy ? 1 : 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            if (busy) nbusy++;
        end
    endtask

    task automatic pop_exp();
        if (sbq.size() > 0) exp_r = sbq.pop_front();
        else exp_r = '1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; A = 16'h1111; B = 16'h0001;
        tick(); tick();
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if ({diff, borrow, overflow, busy, done} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h/%b/%b busy=%b done=%b want 0", diff, borrow, overflow, busy, done);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int cyc, nb;
        issue(16'h24D7, 16'h03FC, 1'b0);
        wait_done(cyc, nb);
        n_checks++;
        if (cyc !== 5) begin
            n_fail++;
            $display("FAIL t1_latency got %0d want 5", cyc);
        end
        n_checks++;
        if (nb !== 4) begin
            n_fail++;
            $display("FAIL t1_busy_cycles got %0d want 4", nb);
        end
        pop_exp();
        n_checks++;
        if ({diff, borrow, overflow} !== {16'h20DB, 1'b0, 1'b0} || exp_r !== {16'h20DB, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL t1_result got %h/%b/%b want 20db/0/0", diff, borrow, overflow);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_borrow_overflow();
        int cyc, nb;
        logic [15:0] ta [3] = '{16'h03FC, 16'h7FFF, 16'h8000};
        logic [15:0] tb [3] = '{16'hFDE8, 16'hFFFF, 16'h0001};
        res_t        tr [3] = '{{16'h0614, 1'b1, 1'b0},
                                {16'h8000, 1'b1, 1'b1},
                                {16'h7FFF, 1'b0, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], 1'b0);
            wait_done(cyc, nb);
            pop_exp();
            n_checks++;
            if ({diff, borrow, overflow} !== tr[i] || exp_r !== tr[i]) begin
                n_fail++;
                $display("FAIL bo_case%0d got %h/%b/%b want %h/%b/%b",
                         i, diff, borrow, overflow, tr[i].d, tr[i].b, tr[i].o);
            end
        end
    endtask

    task automatic test_hold();
        int cyc, nb;
        int held_bad;
        issue(16'h0000, 16'h0000, 1'b1);
        wait_done(cyc, nb);
        pop_exp();
        n_checks++;
        if ({diff, borrow, overflow} !== {16'hFFFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL t4_wrap got %h/%b/%b want ffff/1/0", diff, borrow, overflow);
        end
        issue(16'h1234, 16'h1234, 1'b0);
        held_bad = 0;
        cyc = 0;
        while (!done && cyc < 20) begin
            if ({diff, borrow, overflow} !== {16'hFFFF, 1'b1, 1'b0}) held_bad++;
            tick();
            cyc++;
        end
        n_checks++;
        if (held_bad != 0) begin
            n_fail++;
            $display("FAIL t4_hold got %0d changed cycles want 0", held_bad);
        end
        pop_exp();
        n_checks++;
        if ({diff, borrow, overflow} !== exp_r || cyc != 5) begin
            n_fail++;
            $display("FAIL t4_zero got %h/%b/%b lat %0d want %h/%b/%b lat 5",
                     diff, borrow, overflow, cyc, exp_r.d, exp_r.b, exp_r.o);
        end
    endtask

    task automatic test_ignore_start();
        int cyc, nb;
        int extra;
        issue(16'hA5A5, 16'h1234, 1'b1);
        tick();
        A = 16'h0F0F; B = 16'hF0F0; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        A = 16'h5555; B = 16'h7777; Bin = 1'b1;
        wait_done(cyc, nb);
        n_checks++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL t5_schedule got %0d want 3", cyc);
        end
        pop_exp();
        n_checks++;
        if ({diff, borrow, overflow} !== exp_r) begin
            n_fail++;
            $display("FAIL t5_ignored got %h/%b/%b want %h/%b/%b",
                     diff, borrow, overflow, exp_r.d, exp_r.b, exp_r.o);
        end
        extra = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (done || busy) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL t5_no_second got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, nb;
        issue(16'h8001, 16'h0002, 1'b0);
        tick(); tick(); tick(); tick();
        A = 16'h0100; B = 16'h0001; Bin = 1'b1; start = 1'b1;
        sbq.push_back(model(16'h0100, 16'h0001, 1'b1));
        tick();
        start = 1'b0;
        pop_exp();
        n_checks++;
        if (done !== 1'b1 || {diff, borrow, overflow} !== exp_r) begin
            n_fail++;
            $display("FAIL b2b_first got done=%b %h/%b/%b want done=1 %h/%b/%b",
                     done, diff, borrow, overflow, exp_r.d, exp_r.b, exp_r.o);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept busy got %b want 1", busy);
        end
        tick();
        wait_done(cyc, nb);
        pop_exp();
        n_checks++;
        if (cyc + 1 != 5 || {diff, borrow, overflow} !== exp_r) begin
            n_fail++;
            $display("FAIL b2b_second got %h/%b/%b lat %0d want %h/%b/%b lat 5",
                     diff, borrow, overflow, cyc + 1, exp_r.d, exp_r.b, exp_r.o);
        end
    endtask

    task automatic test_abort();
        int cyc, nb;
        int seen;
        issue(16'h24D7, 16'h03FC, 1'b0);
        void'(sbq.pop_back());
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_abort_busy got %b want 0", busy);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0 || {diff, borrow, overflow} !== 18'h0) begin
            n_fail++;
            $display("FAIL t6_abort_result got done x%0d %h/%b/%b want none 0/0/0",
                     seen, diff, borrow, overflow);
        end
        issue(16'h24D7, 16'h03FC, 1'b0);
        wait_done(cyc, nb);
        pop_exp();
        n_checks++;
        if (diff !== 16'h20DB || {diff, borrow, overflow} !== exp_r || cyc != 5) begin
            n_fail++;
            $display("FAIL t6_restart got %h lat %0d want 20db lat 5", diff, cyc);
        end
    endtask

    task automatic test_random();
        int cyc, nb;
        logic [15:0] ra, rb;
        logic        rbi;
        for (int i = 0; i < 8; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom_range(1));
            issue(ra, rb, rbi);
            wait_done(cyc, nb);
            pop_exp();
            n_checks++;
            if ({diff, borrow, overflow} !== exp_r) begin
                n_fail++;
                $display("FAIL rand%0d %h-%h-%b got %h/%b/%b want %h/%b/%b",
                         i, ra, rb, rbi, diff, borrow, overflow, exp_r.d, exp_r.b, exp_r.o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_overflow();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_random();
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty got %0d entries want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
